// File: rtl/phase_sequencer.sv
// Instruction-phase controller: sequences FETCH/EXEC1/EXEC2/EXEC3 strobes,
// handles free-run and single-step handshake, halts on stp, keeps debug counters.
module phase_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step_req,
    output logic             step_ack,
    input  logic [4:0]       instr_op,
    input  logic             extra,
    input  logic             extra2,
    input  logic             cnt_clr,
    output logic             fetch,
    output logic             exec1,
    output logic             exec2,
    output logic             exec3,
    output logic             instr_done,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_EXEC3,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic              step_mode_q, step_mode_d;
    logic              step_ack_q, step_ack_d;
    logic              fetch_q, exec1_q, exec2_q, exec3_q;
    logic              busy_q, halted_q;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic              stp;
    logic              done;

    assign stp = (instr_op == 5'b11110);

    always_comb begin
        done = 1'b0;
        case (state_q)
            S_EXEC1: done = stp || !extra;
            S_EXEC2: done = !extra2;
            S_EXEC3: done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        step_ack_d  = step_ack_q;
        if (step_ack_q && !step_req)
            step_ack_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // run has priority; a step starts only after the previous ack is retired
                if (run) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                end else if (step_req && !step_ack_q) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            S_FETCH: state_d = S_EXEC1;
            S_EXEC1: begin
                if (stp)
                    state_d = S_HALT;
                else if (extra)
                    state_d = S_EXEC2;
            end
            S_EXEC2: begin
                if (extra2)
                    state_d = S_EXEC3;
            end
            S_EXEC3: state_d = S_EXEC3;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (done) begin
            if (step_mode_q)
                step_ack_d = 1'b1;
            if (!(state_q == S_EXEC1 && stp))
                state_d = run ? S_FETCH : S_IDLE;
            step_mode_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_mode_q <= 1'b0;
            step_ack_q  <= 1'b0;
            fetch_q     <= 1'b0;
            exec1_q     <= 1'b0;
            exec2_q     <= 1'b0;
            exec3_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            step_ack_q  <= step_ack_d;
            fetch_q     <= (state_d == S_FETCH);
            exec1_q     <= (state_d == S_EXEC1);
            exec2_q     <= (state_d == S_EXEC2);
            exec3_q     <= (state_d == S_EXEC3);
            busy_q      <= (state_d == S_FETCH) || (state_d == S_EXEC1) ||
                           (state_d == S_EXEC2) || (state_d == S_EXEC3);
            halted_q    <= (state_d == S_HALT);
        end
    end

    always_comb begin
        if (cnt_clr) begin
            instr_cnt_d = '0;
            cycle_cnt_d = '0;
        end else begin
            instr_cnt_d = instr_cnt_q + CNT_W'(done);
            cycle_cnt_d = cycle_cnt_q + CNT_W'(busy_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign fetch       = fetch_q;
    assign exec1       = exec1_q;
    assign exec2       = exec2_q;
    assign exec3       = exec3_q;
    assign instr_done  = done;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign step_ack    = step_ack_q;
    assign instr_count = instr_cnt_q;
    assign cycle_count = cycle_cnt_q;

endmodule
